// File: rtl/ec_datapath_if.sv
// ----------------------------------------------------------------------------
// ec_datapath_if
//   Bundle between the control unit (master) and the accumulator-processor
//   datapath (slave).
//
//   Control word  (master -> slave): IRload, PCload, JMPmux, Meminst, MemWr,
//                                    Aload, Sub, Halt, Asel[1:0]
//   User input    (master -> slave): Input[DATA_W-1:0]
//   Load port     (master -> slave): LoadEn, LoadAddr[ADDR_W-1:0],
//                                    LoadData[DATA_W-1:0]
//   Status        (slave -> master): IR[2:0] opcode, Aeq0, Apos,
//                                    Output[DATA_W-1:0], PCout[ADDR_W-1:0],
//                                    Halted
// ----------------------------------------------------------------------------
interface ec_datapath_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  // control word
  logic              IRload;
  logic              PCload;
  logic              JMPmux;
  logic              Meminst;
  logic              MemWr;
  logic              Aload;
  logic              Sub;
  logic              Halt;
  logic [1:0]        Asel;
  logic [DATA_W-1:0] Input;

  // external memory load port
  logic              LoadEn;
  logic [ADDR_W-1:0] LoadAddr;
  logic [DATA_W-1:0] LoadData;

  // status back to the control unit
  logic [2:0]        IR;
  logic              Aeq0;
  logic              Apos;
  logic [DATA_W-1:0] Output;
  logic [ADDR_W-1:0] PCout;
  logic              Halted;

  modport master (
    output IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt, Asel,
    output Input, LoadEn, LoadAddr, LoadData,
    input  IR, Aeq0, Apos, Output, PCout, Halted
  );

  modport slave (
    input  IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt, Asel,
    input  Input, LoadEn, LoadAddr, LoadData,
    output IR, Aeq0, Apos, Output, PCout, Halted
  );
endinterface

// File: rtl/ec_datapath.sv
// ----------------------------------------------------------------------------
// ec_datapath
//   Datapath of the 8-bit accumulator processor: program counter, instruction
//   register, accumulator, 2^ADDR_W x DATA_W unified program/data memory with
//   a registered read (Dreg) and the add/subtract unit. It executes the
//   per-state control word and returns opcode and accumulator flags.
//
//   Ports
//     Clock  in   rising-edge clock
//     Reset  in   asynchronous, active-low reset of all registers (not memory)
//     bus    slave side of ec_datapath_if (control word, load port, status)
//
//   Instruction format: {opcode[2:0], address[ADDR_W-1:0]}; DATA_W must
//   equal ADDR_W + 3.
// ----------------------------------------------------------------------------
module ec_datapath #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  ec_datapath_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ASEL_ALU   = 2'b00,
    ASEL_INPUT = 2'b01,
    ASEL_MEM   = 2'b10,
    ASEL_ZERO  = 2'b11
  } asel_e;

  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] dreg;
  logic              halted;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] acc_next;

  // The external load port overrides everything; otherwise operand accesses
  // use the IR address field and instruction fetches use the PC.
  assign mem_addr = bus.LoadEn  ? bus.LoadAddr :
                    bus.Meminst ? ir_reg[ADDR_W-1:0] : pc_reg;

  // NOTE: the memory array is deliberately left out of reset so that it maps
  // onto RAM and so that preloaded programs survive a reset.
  // A processor-side store is suppressed while Reset is low so that an
  // aborted instruction cannot leave a partial write behind; the load port
  // keeps working so memory can be filled while the core is held in reset.
  always_ff @(posedge Clock) begin
    if (bus.LoadEn) begin
      mem[bus.LoadAddr] <= bus.LoadData;
    end else if (bus.MemWr && Reset) begin
      mem[mem_addr] <= acc;
    end
  end

  // Accumulator source mux and add/subtract unit; results wrap at DATA_W.
  always_comb begin
    // NOTE: a default assignment first keeps this combinational block free
    // of inferred latches whatever path the case takes.
    acc_next = acc;
    case (asel_e'(bus.Asel))
      ASEL_ALU:   acc_next = bus.Sub ? (acc - dreg) : (acc + dreg);
      ASEL_INPUT: acc_next = bus.Input;
      ASEL_MEM:   acc_next = dreg;
      ASEL_ZERO:  acc_next = '0;
      default:    acc_next = acc;
    endcase
  end

  // NOTE: every register here uses non-blocking assignments, so each update
  // sees pre-edge values: IRload captures the Dreg staged from the old PC,
  // a same-edge store writes the old accumulator, and the memory read is
  // read-before-write.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_reg <= '0;
      ir_reg <= '0;
      acc    <= '0;
      dreg   <= '0;
      halted <= 1'b0;
    end else begin
      dreg <= mem[mem_addr];
      if (bus.IRload) ir_reg <= dreg;
      if (bus.PCload) pc_reg <= bus.JMPmux ? ir_reg[ADDR_W-1:0]
                                           : pc_reg + ADDR_W'(1);
      if (bus.Aload)  acc    <= acc_next;
      if (bus.Halt)   halted <= 1'b1;
    end
  end

  // Status back to the control unit, combinational from the registers.
  assign bus.IR     = ir_reg[DATA_W-1 -: 3];
  assign bus.Aeq0   = (acc == '0);
  assign bus.Apos   = !acc[DATA_W-1] && (acc != '0);
  assign bus.Output = acc;
  assign bus.PCout  = pc_reg;
  assign bus.Halted = halted;

endmodule

// File: doc/ec_datapath.md
# ec_datapath

Datapath for the 8-bit accumulator processor, directly downstream of the control unit. It holds the program counter, instruction register, accumulator, a 32x8 unified program/data memory and the add/subtract unit. It executes the per-state control word from the control unit and returns the opcode and accumulator status flags that drive the next-state logic. An external load port lets the bench preload memory.

## Interface
- ADDR_W, 5, memory address width; memory depth = 2^ADDR_W.
- DATA_W, 8, data/instruction width; must equal ADDR_W+3 (3-bit opcode + address field).

- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low.
- IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt  in  1 each  control word from the control unit.
- Asel  in  2  accumulator source select.
- Input  in  DATA_W  user input data.
- LoadEn  in  1  external memory write strobe.
- LoadAddr  in  ADDR_W  external write address.
- LoadData  in  DATA_W  external write data.
- IR  out  3  opcode, IRreg[7:5], to the control unit.
- Aeq0  out  1  accumulator == 0.
- Apos  out  1  accumulator > 0 (signed): A[7]==0 and A!=0.
- Output  out  DATA_W  accumulator value.
- PCout  out  ADDR_W  program counter.
- Halted  out  1  sticky halt flag.

## Operation
- Memory address: LoadEn ? LoadAddr : (Meminst ? IRreg[4:0] : PC).
- Memory read is synchronous. Dreg <= mem[addr] every rising edge, read-before-write.
- Write on the rising edge: if LoadEn, mem[LoadAddr] <= LoadData; else if MemWr, mem[addr] <= A. LoadEn wins over MemWr.
- IRreg <= Dreg when IRload. Because of the registered read, the start state (addr=PC) stages the instruction and fetch latches it.
- PC, when PCload: JMPmux ? IRreg[4:0] : PC+1, modulo 2^ADDR_W (31 wraps to 0).
- Accumulator, when Aload, source by Asel:
  - 00: A+Dreg, or A−Dreg if Sub=1. Modulo 256, overflow and carry discarded.
  - 01: Input.
  - 10: Dreg.
  - 11: 0.
- Decode state (Meminst=1) stages the operand into Dreg. load/add/sub consume it in the next cycle.
- Halted <= 1 when Halt=1. It clears only on reset.
- Aeq0, Apos and Output are combinational from A. IR is combinational from IRreg.

## Timing
- Reset low forces, immediately and asynchronously: PC=0, IRreg=0, A=0, Dreg=0, Halted=0. Resulting outputs: IR=000, Aeq0=1, Apos=0, Output=0x00, PCout=0.
- Memory contents are not affected by reset. LoadEn is honoured while Reset is low.
- Reset asserted mid-instruction aborts it. No partial write occurs unless the MemWr/LoadEn edge completed before reset.
- All register updates take effect on the rising edge where the control is high. Flags are valid in the same cycle.
- Instruction latency with control-unit sequencing:
  - load/store/add/sub/jz/jpos: 4 cycles (start, fetch, decode, execute).
  - input: 4 + N cycles, where N is the number of cycles Enter is low; A reloads every input cycle.
- Same-edge IRload and PCload: IRload captures the Dreg staged from the old PC; PC increments.
- Same-edge MemWr and Aload cannot occur from valid control. If forced, the write uses the old A.

## Test plan
- Reset: hold Reset=0 with random control inputs -> IR=000, Aeq0=1, Apos=0, Output=0, PCout=0, Halted=0. Preload mem[5]=0xAA via LoadEn and release reset -> mem[5] still 0xAA.
- Program: preload mem0=0x10 (load 16), mem1=0x51 (add 17), mem2=0x32 (store 18), mem3=0xE0 (halt), mem16=0x05, mem17=0x03. Drive the control-unit state sequence -> Output=0x08, mem18=0x08, PCout=4, Halted=1 after 16 cycles.
- Subtract wrap: A=0x02, operand 0x05, Asel=00, Sub=1, Aload=1 -> Output=0xFD, Aeq0=0, Apos=0.
- Jumps: A=0, IRreg=0xAA (jz 10), JMPmux=1, PCload=1 -> PCout=0x0A. PC=31 with PCload=1, JMPmux=0 -> PCout=0.
- Input: Asel=01, Aload=1, Input=0x7F -> Output=0x7F, Apos=1. Input=0x00 -> Aeq0=1, Apos=0.
- Write precedence: LoadEn=1, LoadAddr=3, LoadData=0x11, together with MemWr=1, IR address 9, A=0x22 -> mem3=0x11, mem9 unchanged.
